// File: rtl/frame_fifo_mc.sv
// Channel-masked frame assembler feeding a FRAME_DEPTH-deep frame FIFO with drop/overwrite overflow policy.
// Optional frame tagging is enabled by defining FRAME_FIFO_MC_TAG_EN.
module frame_fifo_mc #(
    parameter int NUM_CH      = 8,
    parameter int WORD_W      = 16,
    parameter int FRAME_DEPTH = 16,
    parameter int OVF_MODE    = 0,
    localparam int ADDR_W     = $clog2(FRAME_DEPTH)
) (
    input  logic                       SAMPLE_CLK,
    input  logic                       RST_sync,
    input  logic                       ENSAMP_sync,
    input  logic [WORD_W-1:0]          RESULT,
    input  logic                       DONE,
    input  logic [NUM_CH-1:0]          CHSEL,
    input  logic [NUM_CH-1:0]          CHMASK,
    input  logic [ADDR_W:0]            WATERMARK,
    input  logic                       FIFO_POP,
    output logic [NUM_CH*WORD_W-1:0]   FRAME_DATA,
    output logic [NUM_CH-1:0]          FRAME_CHMASK,
    output logic                       FRAME_VALID,
    output logic [ADDR_W:0]            FILL_LEVEL,
    output logic                       DATA_RDY,
    output logic                       OVERFLOW_PULSE,
`ifdef FRAME_FIFO_MC_TAG_EN
    output logic [7:0]                 FRAME_TAG,
`endif
    output logic                       UNDERFLOW_PULSE
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FRAME_DEPTH);

    logic [NUM_CH*WORD_W-1:0] r_mem_data [FRAME_DEPTH];
    logic [NUM_CH-1:0]        r_mem_mask [FRAME_DEPTH];

    logic [NUM_CH*WORD_W-1:0] r_stg_data;
    logic [NUM_CH-1:0]        r_stg_mask;
    logic [ADDR_W:0]          r_wr_ptr;
    logic [ADDR_W:0]          r_rd_ptr;
    logic [ADDR_W:0]          r_fill;
    logic [NUM_CH*WORD_W-1:0] r_frame_data;
    logic [NUM_CH-1:0]        r_frame_mask;
    logic                     r_valid;
    logic                     r_ovf;
    logic                     r_unf;

    logic                     w_onehot;
    logic                     w_accept;
    logic                     w_commit;
    logic [NUM_CH*WORD_W-1:0] w_frame_data;
    logic [NUM_CH-1:0]        w_frame_mask;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_rd_ok;
    logic                     w_ovf;
    logic                     w_wr_en;
    logic                     w_rd_adv;
    logic [ADDR_W:0]          w_wr_nxt;
    logic [ADDR_W:0]          w_rd_nxt;
    logic [ADDR_W:0]          w_wm_eff;

    always_comb begin
        w_onehot     = (CHSEL != '0) && ((CHSEL & (CHSEL - NUM_CH'(1))) == '0);
        w_accept     = ENSAMP_sync && DONE && w_onehot && ((CHSEL & CHMASK) != '0);
        w_commit     = w_accept && (((r_stg_mask | CHSEL) & CHMASK) == CHMASK);
        w_frame_mask = r_stg_mask | CHSEL;
        w_frame_data = r_stg_data;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (CHSEL[k]) w_frame_data[k*WORD_W +: WORD_W] = RESULT;
        end
        w_full   = (r_fill == DEPTH_L);
        w_empty  = (r_fill == '0);
        w_rd_ok  = FIFO_POP && !w_empty;
        // A same-cycle pop frees the slot, so only an unpopped full commit is an overflow.
        w_ovf    = w_commit && w_full && !FIFO_POP;
        w_wr_en  = w_commit && !(w_ovf && (OVF_MODE == 0));
        w_rd_adv = w_rd_ok || (w_ovf && (OVF_MODE != 0));
        w_wr_nxt = r_wr_ptr + (ADDR_W+1)'(w_wr_en);
        w_rd_nxt = r_rd_ptr + (ADDR_W+1)'(w_rd_adv);
        w_wm_eff = (WATERMARK == '0) ? (ADDR_W+1)'(1) : WATERMARK;
    end

    assign FRAME_DATA      = r_frame_data;
    assign FRAME_CHMASK    = r_frame_mask;
    assign FRAME_VALID     = r_valid;
    assign FILL_LEVEL      = r_fill;
    assign OVERFLOW_PULSE  = r_ovf;
    assign UNDERFLOW_PULSE = r_unf;
    assign DATA_RDY        = ENSAMP_sync && (r_fill >= w_wm_eff);

`ifdef FRAME_FIFO_MC_TAG_EN
    logic [7:0] r_mem_tag [FRAME_DEPTH];
    logic [7:0] r_tag_cnt;
    logic [7:0] r_tag;

    assign FRAME_TAG = r_tag;

    always_ff @(posedge SAMPLE_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            r_tag_cnt <= '0;
            r_tag     <= '0;
        end else if (!ENSAMP_sync) begin
            r_tag_cnt <= '0;
            r_tag     <= '0;
        end else begin
            if (w_commit) r_tag_cnt <= r_tag_cnt + 8'd1;
            if (FIFO_POP) r_tag <= w_empty ? '0 : r_mem_tag[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge SAMPLE_CLK) begin
        if (w_wr_en && !RST_sync) r_mem_tag[r_wr_ptr[ADDR_W-1:0]] <= r_tag_cnt + 8'd1;
    end
`endif

    always_ff @(posedge SAMPLE_CLK) begin
        if (w_wr_en && !RST_sync) begin
            r_mem_data[r_wr_ptr[ADDR_W-1:0]] <= w_frame_data;
            r_mem_mask[r_wr_ptr[ADDR_W-1:0]] <= w_frame_mask;
        end
    end

    always_ff @(posedge SAMPLE_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_stg_data   <= '0;
            r_stg_mask   <= '0;
            r_frame_data <= '0;
            r_frame_mask <= '0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else if (!ENSAMP_sync) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_stg_data   <= '0;
            r_stg_mask   <= '0;
            r_frame_data <= '0;
            r_frame_mask <= '0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_fill   <= w_wr_nxt - w_rd_nxt;
            if (w_commit) begin
                r_stg_data <= '0;
                r_stg_mask <= '0;
            end else if (w_accept) begin
                r_stg_data <= w_frame_data;
                r_stg_mask <= w_frame_mask;
            end
            r_valid <= 1'b0;
            r_unf   <= 1'b0;
            r_ovf   <= w_ovf;
            if (FIFO_POP) begin
                if (w_empty) begin
                    r_frame_data <= '0;
                    r_frame_mask <= '0;
                    r_unf        <= 1'b1;
                end else begin
                    r_frame_data <= r_mem_data[r_rd_ptr[ADDR_W-1:0]];
                    r_frame_mask <= r_mem_mask[r_rd_ptr[ADDR_W-1:0]];
                    r_valid      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo_mc.sv
// Bench for frame_fifo_mc: drop and overwrite instances share stimulus and are checked against a queue model.
module tb_frame_fifo_mc;

    localparam int NC    = 8;
    localparam int WW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = NC*WW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NC-1:0] mask;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          done = 1'b0;
    logic          pop = 1'b0;
    logic [WW-1:0] result = '0;
    logic [NC-1:0] chsel = '0;
    logic [NC-1:0] chmask = '0;
    logic [AW:0]   wm = '0;

    logic [1:0][DW-1:0] d_data;
    logic [1:0][NC-1:0] d_mask;
    logic [1:0][AW:0]   d_fill;
    logic [1:0]         d_valid, d_rdy, d_ovf, d_unf;

    frame_t             fq [2][$];
    logic [1:0][DW-1:0] e_data;
    logic [1:0][NC-1:0] e_mask;
    logic [1:0]         e_valid, e_unf, e_ovf;
    logic [DW-1:0]      stg_data;
    logic [NC-1:0]      stg_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_fifo_mc #(.NUM_CH(NC), .WORD_W(WW), .FRAME_DEPTH(DEPTH), .OVF_MODE(0)) u_drop (
        .SAMPLE_CLK(clk), .RST_sync(rst), .ENSAMP_sync(en), .RESULT(result), .DONE(done),
        .CHSEL(chsel), .CHMASK(chmask), .WATERMARK(wm), .FIFO_POP(pop),
        .FRAME_DATA(d_data[0]), .FRAME_CHMASK(d_mask[0]), .FRAME_VALID(d_valid[0]),
        .FILL_LEVEL(d_fill[0]), .DATA_RDY(d_rdy[0]), .OVERFLOW_PULSE(d_ovf[0]),
        .UNDERFLOW_PULSE(d_unf[0])
    );

    frame_fifo_mc #(.NUM_CH(NC), .WORD_W(WW), .FRAME_DEPTH(DEPTH), .OVF_MODE(1)) u_ovw (
        .SAMPLE_CLK(clk), .RST_sync(rst), .ENSAMP_sync(en), .RESULT(result), .DONE(done),
        .CHSEL(chsel), .CHMASK(chmask), .WATERMARK(wm), .FIFO_POP(pop),
        .FRAME_DATA(d_data[1]), .FRAME_CHMASK(d_mask[1]), .FRAME_VALID(d_valid[1]),
        .FILL_LEVEL(d_fill[1]), .DATA_RDY(d_rdy[1]), .OVERFLOW_PULSE(d_ovf[1]),
        .UNDERFLOW_PULSE(d_unf[1])
    );

    // Reference model: a frame queue per overflow policy, advanced once per clock from the inputs.
    task automatic model_step();
        logic   acc, commit;
        frame_t nf, f;
        int     sz;
        if (rst || !en) begin
            for (int m = 0; m < 2; m++) fq[m].delete();
            e_data = '0; e_mask = '0; e_valid = '0; e_unf = '0; e_ovf = '0;
            stg_data = '0; stg_mask = '0;
            return;
        end
        acc    = done && ($countones(chsel) == 1) && ((chsel & chmask) != '0);
        commit = acc && (((stg_mask | chsel) & chmask) == chmask);
        nf.data = stg_data;
        nf.mask = stg_mask | chsel;
        for (int k = 0; k < NC; k++) if (chsel[k]) nf.data[k*WW +: WW] = result;
        for (int m = 0; m < 2; m++) begin
            sz = fq[m].size();
            e_valid[m] = 1'b0; e_unf[m] = 1'b0; e_ovf[m] = 1'b0;
            if (pop) begin
                if (sz > 0) begin
                    f = fq[m].pop_front();
                    e_data[m] = f.data; e_mask[m] = f.mask; e_valid[m] = 1'b1;
                end else begin
                    e_data[m] = '0; e_mask[m] = '0; e_unf[m] = 1'b1;
                end
            end
            if (commit) begin
                if (sz == DEPTH && !pop) begin
                    e_ovf[m] = 1'b1;
                    if (m == 1) begin
                        void'(fq[m].pop_front());
                        fq[m].push_back(nf);
                    end
                end else begin
                    fq[m].push_back(nf);
                end
            end
        end
        if (commit) begin
            stg_data = '0; stg_mask = '0;
        end else if (acc) begin
            stg_data = nf.data; stg_mask = nf.mask;
        end
    endtask

    function automatic logic exp_rdy(int m);
        int w;
        w = (wm == 0) ? 1 : int'(wm);
        return en && !rst && (fq[m].size() >= w);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int ch, input logic [WW-1:0] v);
        done = 1'b1; chsel = NC'(1) << ch; result = v;
        tick();
        done = 1'b0; chsel = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_fill[m] !== '0) begin n_fail++; $display("FAIL reset_fill[%0d]: got %0d want 0", m, d_fill[m]); end
            n_checks++; if (d_data[m] !== '0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", m, d_data[m]); end
            n_checks++; if ({d_valid[m], d_rdy[m], d_ovf[m], d_unf[m]} !== 4'b0) begin
                n_fail++; $display("FAIL reset_flags[%0d]: got %b want 0000", m, {d_valid[m], d_rdy[m], d_ovf[m], d_unf[m]});
            end
        end
        rst = 1'b0; en = 1'b1; wm = 3'd1;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] want;
        want = {64'h0, 64'h1003_1002_1001_1000};
        chmask = 8'h0F;
        for (int ch = 0; ch < 4; ch++) begin
            send_word(ch, WW'(16'h1000 + ch));
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_fill[m] !== ((ch == 3) ? 3'd1 : 3'd0)) begin
                    n_fail++; $display("FAIL basic_fill[%0d] ch%0d: got %0d", m, ch, d_fill[m]);
                end
            end
        end
        pop = 1'b1; tick(); pop = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_data[m] !== want) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", m, d_data[m], want); end
            n_checks++; if (d_mask[m] !== 8'h0F) begin n_fail++; $display("FAIL basic_mask[%0d]: got %h want 0f", m, d_mask[m]); end
            n_checks++; if (d_valid[m] !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want 1", m, d_valid[m]); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_valid[m] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end[%0d]: got %b want 0", m, d_valid[m]); end
            n_checks++; if (d_data[m] !== want) begin n_fail++; $display("FAIL basic_hold[%0d]: got %h want %h", m, d_data[m], want); end
        end
    endtask

    task automatic test_underflow();
        pop = 1'b1; tick(); pop = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_unf[m] !== 1'b1) begin n_fail++; $display("FAIL unf_pulse[%0d]: got %b want 1", m, d_unf[m]); end
            n_checks++; if (d_data[m] !== '0 || d_mask[m] !== '0) begin
                n_fail++; $display("FAIL unf_data[%0d]: got %h/%h want 0/0", m, d_data[m], d_mask[m]);
            end
            n_checks++; if (d_valid[m] !== 1'b0 || d_fill[m] !== '0) begin
                n_fail++; $display("FAIL unf_state[%0d]: valid %b fill %0d want 0 0", m, d_valid[m], d_fill[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_unf[m] !== 1'b0) begin n_fail++; $display("FAIL unf_end[%0d]: got %b want 0", m, d_unf[m]); end
        end
    endtask

    task automatic test_overflow();
        chmask = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            send_word(0, WW'(k));
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_ovf[m] !== (k == 5)) begin n_fail++; $display("FAIL ovf_pulse[%0d] k%0d: got %b", m, k, d_ovf[m]); end
                n_checks++; if (d_fill[m] !== ((k > 4) ? 3'd4 : 3'(k))) begin
                    n_fail++; $display("FAIL ovf_fill[%0d] k%0d: got %0d", m, k, d_fill[m]);
                end
            end
        end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_data[m][WW-1:0] !== WW'(i + 1 + m) || d_valid[m] !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_pop[%0d] #%0d: got %h valid %b want %0d", m, i, d_data[m][WW-1:0], d_valid[m], i + 1 + m);
                end
                n_checks++; if (d_ovf[m] !== 1'b0) begin n_fail++; $display("FAIL ovf_after[%0d]: got %b want 0", m, d_ovf[m]); end
            end
        end
        pop = 1'b0; tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_fill[m] !== '0) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %0d want 0", m, d_fill[m]); end
        end
    endtask

    task automatic test_full_commit_pop();
        chmask = 8'h01;
        for (int k = 11; k <= 14; k++) send_word(0, WW'(k));
        done = 1'b1; chsel = 8'h01; result = 16'd15; pop = 1'b1;
        tick();
        done = 1'b0; chsel = '0;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_ovf[m] !== 1'b0) begin n_fail++; $display("FAIL fcp_ovf[%0d]: got %b want 0", m, d_ovf[m]); end
            n_checks++; if (d_fill[m] !== 3'd4) begin n_fail++; $display("FAIL fcp_fill[%0d]: got %0d want 4", m, d_fill[m]); end
            n_checks++; if (d_data[m][WW-1:0] !== 16'd11) begin n_fail++; $display("FAIL fcp_first[%0d]: got %0d want 11", m, d_data[m][WW-1:0]); end
        end
        for (int i = 12; i <= 15; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_data[m][WW-1:0] !== WW'(i) || d_valid[m] !== 1'b1) begin
                    n_fail++; $display("FAIL fcp_pop[%0d]: got %0d valid %b want %0d", m, d_data[m][WW-1:0], d_valid[m], i);
                end
            end
        end
        pop = 1'b0; tick();
    endtask

    task automatic test_watermark();
        chmask = 8'h01; wm = 3'd3;
        send_word(0, 16'd1); send_word(0, 16'd2);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_fill[m] !== 3'd2 || d_rdy[m] !== 1'b0) begin
                n_fail++; $display("FAIL wm3_at2[%0d]: fill %0d rdy %b want 2 0", m, d_fill[m], d_rdy[m]);
            end
        end
        send_word(0, 16'd3);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_rdy[m] !== 1'b1) begin n_fail++; $display("FAIL wm3_at3[%0d]: got %b want 1", m, d_rdy[m]); end
        end
        pop = 1'b1; tick(); tick(); tick(); pop = 1'b0;
        wm = 3'd0; #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_rdy[m] !== 1'b0) begin n_fail++; $display("FAIL wm0_at0[%0d]: got %b want 0", m, d_rdy[m]); end
        end
        send_word(0, 16'd4);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_rdy[m] !== 1'b1) begin n_fail++; $display("FAIL wm0_at1[%0d]: got %b want 1", m, d_rdy[m]); end
        end
        pop = 1'b1; tick(); pop = 1'b0; wm = 3'd1;
    endtask

    task automatic test_ensamp_drop();
        logic [DW-1:0] want;
        want = {64'h0, 64'hBB03_BB02_BB01_BB00};
        chmask = 8'h01; send_word(0, 16'd7);
        chmask = 8'h0F; send_word(0, 16'hAA00); send_word(1, 16'hAA01);
        en = 1'b0; tick();
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_fill[m] !== '0 || d_rdy[m] !== 1'b0) begin
                n_fail++; $display("FAIL ens_clear[%0d]: fill %0d rdy %b want 0 0", m, d_fill[m], d_rdy[m]);
            end
        end
        en = 1'b1;
        send_word(2, 16'hBB02); send_word(3, 16'hBB03);
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_fill[m] !== '0) begin n_fail++; $display("FAIL ens_stale[%0d]: got %0d want 0", m, d_fill[m]); end
        end
        send_word(0, 16'hBB00); send_word(1, 16'hBB01);
        pop = 1'b1; tick(); pop = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_data[m] !== want || d_mask[m] !== 8'h0F) begin
                n_fail++; $display("FAIL ens_frame[%0d]: got %h/%h want %h/0f", m, d_data[m], d_mask[m], want);
            end
        end
    endtask

    task automatic test_random();
        logic [NC-1:0] masks [7];
        int            r, pop_pct;
        masks = '{8'h00, 8'h01, 8'h03, 8'h0F, 8'hF0, 8'h81, 8'hFF};
        for (int i = 0; i < 600; i++) begin
            pop_pct = (i < 300) ? 10 : 45;
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 39) != 0);
            done = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r < 8)       chsel = NC'(1) << $urandom_range(0, NC - 1);
            else if (r == 8) chsel = '0;
            else             chsel = NC'($urandom);
            if ($urandom_range(0, 24) == 0) chmask = masks[$urandom_range(0, 6)];
            pop    = ($urandom_range(0, 99) < pop_pct);
            wm     = 3'($urandom_range(0, 4));
            result = WW'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_fill[m] !== 3'(fq[m].size())) begin
                    n_fail++; $display("FAIL rnd_fill[%0d] cyc%0d: got %0d want %0d", m, i, d_fill[m], fq[m].size());
                end
                n_checks++; if ({d_valid[m], d_unf[m], d_ovf[m]} !== {e_valid[m], e_unf[m], e_ovf[m]}) begin
                    n_fail++; $display("FAIL rnd_pulses[%0d] cyc%0d: got %b want %b", m, i,
                                       {d_valid[m], d_unf[m], d_ovf[m]}, {e_valid[m], e_unf[m], e_ovf[m]});
                end
                n_checks++; if (d_data[m] !== e_data[m] || d_mask[m] !== e_mask[m]) begin
                    n_fail++; $display("FAIL rnd_frame[%0d] cyc%0d: got %h/%h want %h/%h", m, i, d_data[m], d_mask[m], e_data[m], e_mask[m]);
                end
                n_checks++; if (d_rdy[m] !== exp_rdy(m)) begin
                    n_fail++; $display("FAIL rnd_rdy[%0d] cyc%0d: got %b want %b", m, i, d_rdy[m], exp_rdy(m));
                end
            end
        end
        rst = 1'b0; en = 1'b1; done = 1'b0; pop = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underflow();
        test_overflow();
        test_full_commit_pop();
        test_watermark();
        test_ensamp_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_fifo_mc.md
# frame_fifo_mc

Single-clock, parametrised successor to the ADC frame FIFO, sitting in the SAMPLE_CLK domain between the SAR conversion sequencer and the readout/CDC stage. It assembles per-channel conversion results into frames of NUM_CH words, completing each frame against a runtime channel mask rather than a LASTWORD strobe. Completed frames are buffered FRAME_DEPTH deep with a selectable overflow policy. The block exposes fill level, watermark, a per-frame channel-valid mask, and single-cycle overflow/underflow pulses.

## Interface
- NUM_CH, 8: channels per frame, 1..16
- WORD_W, 16: bits per conversion result
- FRAME_DEPTH, 16: stored frames; power of 2, ≥2; ADDR_W = $clog2(FRAME_DEPTH)
- OVF_MODE, 0: 0 = drop the incoming frame when full; 1 = overwrite the oldest frame
- SAMPLE_CLK  in  1  the only clock; all logic on its rising edge
- RST_sync  in  1  asynchronous, active-high reset
- ENSAMP_sync  in  1  synchronous enable; low clears block state
- RESULT  in  WORD_W  conversion result
- DONE  in  1  RESULT valid this cycle
- CHSEL  in  NUM_CH  one-hot channel of RESULT
- CHMASK  in  NUM_CH  channels enabled for frame completion
- WATERMARK  in  ADDR_W+1  DATA_RDY threshold
- FIFO_POP  in  1  one-cycle pop request
- FRAME_DATA  out  NUM_CH*WORD_W  popped frame; channel k at bits [k*WORD_W +: WORD_W]
- FRAME_CHMASK  out  NUM_CH  channels actually written in the popped frame
- FRAME_VALID  out  1  one-cycle pulse: FRAME_DATA was loaded from the FIFO
- FILL_LEVEL  out  ADDR_W+1  stored frames, 0..FRAME_DEPTH
- DATA_RDY  out  1  watermark reached
- OVERFLOW_PULSE  out  1  one-cycle pulse: a commit happened while full
- UNDERFLOW_PULSE  out  1  one-cycle pulse: a pop happened while empty

## Operation
- Reset (RST_sync high): pointers, FILL_LEVEL, staging register and staging mask go to 0; every output is 0.
- ENSAMP_sync low: same clear, applied synchronously. No pulses are generated. Memory contents need not be cleared.
- Accept rule: DONE is accepted only when ENSAMP_sync=1, CHSEL is exactly one-hot, and (CHSEL & CHMASK) is nonzero. Any other DONE is ignored.
- On accept: RESULT is written into the staging slot and the staging-mask bit is set. A repeat write to the same channel overwrites the slot.
- Commit condition: (staging_mask | CHSEL) covers CHMASK, evaluated against the CHMASK value present on the completing cycle.
- On commit: the staging frame (unwritten channels = 0) and its mask are pushed, then staging is cleared.
- CHMASK = 0: no accepts and no commits.
- Pop with FILL_LEVEL>0: head frame goes to FRAME_DATA/FRAME_CHMASK, FRAME_VALID pulses, read pointer advances.
- Pop with FILL_LEVEL=0: FRAME_DATA and FRAME_CHMASK are set to 0, UNDERFLOW_PULSE fires, no FRAME_VALID.
- FRAME_DATA holds its value between pops.
- Full + commit + no pop:
  - OVF_MODE=0: the frame is discarded.
  - OVF_MODE=1: the frame is written at the write pointer and both pointers advance.
  - Either mode: OVERFLOW_PULSE fires and FILL_LEVEL stays at FRAME_DEPTH.
- Full + commit + pop on the same cycle: both operations occur, no overflow, FILL_LEVEL unchanged.
- Empty + commit + pop on the same cycle: the pop underflows and the committed frame is stored (FILL_LEVEL becomes 1).
- Pointers are ADDR_W+1 bits binary and wrap modulo 2*FRAME_DEPTH. FILL_LEVEL = wr_ptr − rd_ptr, registered.
- DATA_RDY = ENSAMP_sync && FILL_LEVEL ≥ max(WATERMARK,1).

## Timing
- Commit latency: the DONE that completes a frame at edge n gives FILL_LEVEL+1 after edge n. That frame is poppable from edge n+1.
- Pop latency: FIFO_POP sampled at edge n gives FRAME_DATA, FRAME_VALID, or UNDERFLOW_PULSE after edge n, lasting one cycle (FRAME_DATA persists).
- OVERFLOW_PULSE is registered and asserts after the committing edge.
- DATA_RDY is combinational from registered FILL_LEVEL and the inputs; it has no extra latency.
- Back-to-back pops on consecutive cycles are supported, one frame per cycle.

## Configuration
- FRAME_FIFO_MC_TAG_EN defined:
  - An 8-bit frame counter increments on every commit, including dropped ones.
  - The counter value is stored with each frame and output on port FRAME_TAG (out, 8), updated with FRAME_DATA.
  - Gaps in FRAME_TAG expose OVF_MODE=0 drops; jumps expose OVF_MODE=1 overwrites.
  - The counter resets to 0 on RST_sync and when ENSAMP_sync is low.
- Not defined: port FRAME_TAG, the counter and the tag storage are absent.

## Test plan
- NUM_CH=8, CHMASK=8'h0F; DONE on ch0..3 with RESULT=16'h1000+ch; pop → FRAME_DATA[63:0]=64'h1003_1002_1001_1000, upper 64 bits 0, FRAME_CHMASK=8'h0F, FRAME_VALID for 1 cycle.
- Pop on empty FIFO → UNDERFLOW_PULSE for 1 cycle, FRAME_DATA=0, FILL_LEVEL stays 0.
- OVF_MODE=0, FRAME_DEPTH=4: commit 5 frames tagged 1..5 → OVERFLOW_PULSE on the 5th; 4 pops return 1,2,3,4. Repeat with OVF_MODE=1 → pops return 2,3,4,5.
- FIFO full, frame completes and pop issued on the same cycle → no OVERFLOW_PULSE; FILL_LEVEL stays 4; pops return the expected frames in order.
- WATERMARK=3: DATA_RDY low at FILL_LEVEL 2, high at 3. WATERMARK=0: high at 1.
- ENSAMP_sync dropped mid-frame (2 of 4 channels written) → FILL_LEVEL=0 and staging cleared. After re-enable, the next frame holds only new data.
